// File: rtl/decode_issue_unit_if.sv
// Fetch->decode stream, per-pipe issue bundle and writeback completion for decode_issue_unit.
interface decode_issue_unit_if #(
    parameter int unsigned p_seq_num_bits = 5
);
    logic                      f_val;
    logic                      f_rdy;
    logic [31:0]               f_inst;
    logic [31:0]               f_pc;
    logic [p_seq_num_bits-1:0] f_seq_num;

    logic [1:0]                x_val;
    logic [1:0]                x_rdy;
    logic [31:0]               x_pc;
    logic [p_seq_num_bits-1:0] x_seq_num;
    logic [3:0]                x_uop;
    logic [4:0]                x_rs1;
    logic [4:0]                x_rs2;
    logic [4:0]                x_rd;
    logic [31:0]               x_imm;
    logic                      x_wen;

    logic                      cmpl_val;
    logic [4:0]                cmpl_rd;
    logic                      cmpl_wen;

    modport master (
        output f_val, f_inst, f_pc, f_seq_num, x_rdy, cmpl_val, cmpl_rd, cmpl_wen,
        input  f_rdy, x_val, x_pc, x_seq_num, x_uop, x_rs1, x_rs2, x_rd, x_imm, x_wen
    );

    modport slave (
        input  f_val, f_inst, f_pc, f_seq_num, x_rdy, cmpl_val, cmpl_rd, cmpl_wen,
        output f_rdy, x_val, x_pc, x_seq_num, x_uop, x_rs1, x_rs2, x_rd, x_imm, x_wen
    );
endinterface

// File: rtl/decode_issue_unit.sv
// In-order decode/issue stage: one-entry decoded holding register plus pending-write scoreboard.
// Define DECODE_ISSUE_CMPL_BYPASS_EN to let same-cycle completions clear hazards.
module decode_issue_unit #(
    parameter int unsigned p_seq_num_bits = 5
) (
    input logic           clk,
    input logic           rst,
    decode_issue_unit_if.slave bus
);
    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [3:0] UopAdd = 4'd0, UopSub = 4'd1, UopAnd = 4'd2, UopOr = 4'd3;
    localparam logic [3:0] UopXor = 4'd4, UopSlt = 4'd5, UopSltu = 4'd6, UopSll = 4'd7;
    localparam logic [3:0] UopSrl = 4'd8, UopSra = 4'd9, UopAuipc = 4'd10, UopMul = 4'd12;
    localparam logic [3:0] UopIllegal = 4'd15;

    localparam logic [6:0] OpcOpImm = 7'b0010011, OpcOp = 7'b0110011;
    localparam logic [6:0] OpcLui = 7'b0110111, OpcAuipc = 7'b0010111;

    state_e                    state_q, state_d;
    logic [31:0]               pc_q, imm_q, pending_q, pending_d;
    logic [p_seq_num_bits-1:0] seq_q;
    logic [3:0]                uop_q;
    logic [4:0]                rs1_q, rs2_q, rd_q;
    logic                      wen_q, pipe_q;

    logic [6:0]  opc, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_sh, imm_u;
    logic [3:0]  dec_uop;
    logic        dec_pipe, dec_legal, use_rs1, use_rs2, use_rd;
    logic [31:0] dec_imm_raw;

    assign opc    = bus.f_inst[6:0];
    assign funct3 = bus.f_inst[14:12];
    assign funct7 = bus.f_inst[31:25];
    assign imm_i  = {{20{bus.f_inst[31]}}, bus.f_inst[31:20]};
    assign imm_sh = {27'd0, bus.f_inst[24:20]};
    assign imm_u  = {bus.f_inst[31:12], 12'd0};

    always_comb begin
        dec_uop     = UopIllegal;
        dec_pipe    = 1'b0;
        dec_imm_raw = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        use_rd      = 1'b0;
        case (opc)
            OpcOpImm: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec_imm_raw = imm_i;
                case (funct3)
                    3'b000: dec_uop = UopAdd;
                    3'b010: dec_uop = UopSlt;
                    3'b011: dec_uop = UopSltu;
                    3'b100: dec_uop = UopXor;
                    3'b110: dec_uop = UopOr;
                    3'b111: dec_uop = UopAnd;
                    3'b001: begin
                        dec_imm_raw = imm_sh;
                        if (funct7 == 7'h00) dec_uop = UopSll;
                    end
                    3'b101: begin
                        dec_imm_raw = imm_sh;
                        if (funct7 == 7'h00)      dec_uop = UopSrl;
                        else if (funct7 == 7'h20) dec_uop = UopSra;
                    end
                endcase
            end
            OpcOp: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                case (funct7)
                    7'h00: begin
                        case (funct3)
                            3'b000: dec_uop = UopAdd;
                            3'b001: dec_uop = UopSll;
                            3'b010: dec_uop = UopSlt;
                            3'b011: dec_uop = UopSltu;
                            3'b100: dec_uop = UopXor;
                            3'b101: dec_uop = UopSrl;
                            3'b110: dec_uop = UopOr;
                            3'b111: dec_uop = UopAnd;
                        endcase
                    end
                    7'h20: begin
                        if (funct3 == 3'b000)      dec_uop = UopSub;
                        else if (funct3 == 3'b101) dec_uop = UopSra;
                    end
                    7'h01: begin
                        if (funct3 == 3'b000) begin
                            dec_uop  = UopMul;
                            dec_pipe = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OpcLui: begin
                dec_uop     = UopAdd;
                use_rd      = 1'b1;
                dec_imm_raw = imm_u;
            end
            OpcAuipc: begin
                dec_uop     = UopAuipc;
                use_rd      = 1'b1;
                dec_imm_raw = imm_u;
            end
            default: ;
        endcase
    end

    // Illegal encodings carry no register usage so they can never stall or touch the scoreboard.
    assign dec_legal = (dec_uop != UopIllegal);

    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    assign dec_rs1 = (dec_legal && use_rs1) ? bus.f_inst[19:15] : 5'd0;
    assign dec_rs2 = (dec_legal && use_rs2) ? bus.f_inst[24:20] : 5'd0;
    assign dec_rd  = (dec_legal && use_rd) ? bus.f_inst[11:7] : 5'd0;

    logic [31:0] clr_mask, set_mask, pend_eff;
    logic        full, hazard, issue_val, issue_xfer, f_xfer;

    assign clr_mask = (bus.cmpl_val && bus.cmpl_wen && bus.cmpl_rd != 5'd0)
                      ? (32'd1 << bus.cmpl_rd) : 32'd0;
`ifdef DECODE_ISSUE_CMPL_BYPASS_EN
    assign pend_eff = {pending_q[31:1] & ~clr_mask[31:1], 1'b0};
`else
    assign pend_eff = {pending_q[31:1], 1'b0};
`endif

    assign full       = (state_q == StFull);
    assign hazard     = pend_eff[rs1_q] | pend_eff[rs2_q] | (wen_q & pend_eff[rd_q]);
    assign issue_val  = full & ~hazard;
    assign issue_xfer = issue_val & bus.x_rdy[pipe_q];
    assign f_xfer     = bus.f_val & bus.f_rdy;
    assign set_mask   = (issue_xfer && wen_q) ? (32'd1 << rd_q) : 32'd0;
    assign pending_d  = (pending_q & ~clr_mask) | set_mask;

    always_comb begin
        state_d = state_q;
        if (f_xfer)          state_d = StFull;
        else if (issue_xfer) state_d = StEmpty;
    end

    assign bus.f_rdy     = ~full | issue_xfer;
    assign bus.x_val     = issue_val ? (pipe_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.x_pc      = pc_q;
    assign bus.x_seq_num = seq_q;
    assign bus.x_uop     = uop_q;
    assign bus.x_rs1     = rs1_q;
    assign bus.x_rs2     = rs2_q;
    assign bus.x_rd      = rd_q;
    assign bus.x_imm     = imm_q;
    assign bus.x_wen     = wen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            pending_q <= '0;
            pc_q      <= '0;
            seq_q     <= '0;
            uop_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            wen_q     <= 1'b0;
            pipe_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (f_xfer) begin
                pc_q   <= bus.f_pc;
                seq_q  <= bus.f_seq_num;
                uop_q  <= dec_uop;
                rs1_q  <= dec_rs1;
                rs2_q  <= dec_rs2;
                rd_q   <= dec_rd;
                imm_q  <= dec_legal ? dec_imm_raw : 32'd0;
                wen_q  <= dec_legal && use_rd && (bus.f_inst[11:7] != 5'd0);
                pipe_q <= dec_pipe;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_unit.sv
// Self-checking bench for decode_issue_unit: directed scenarios plus a randomized run
// against a transaction-level model of decode, scoreboard and issue.
module tb_decode_issue_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    decode_issue_unit_if #(.p_seq_num_bits(5)) bus ();

    decode_issue_unit #(.p_seq_num_bits(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  uop;
        logic        pipe;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wen;
    } dec_t;

    // Reference decode written from the mnemonic rules.
    function automatic dec_t ref_decode(input logic [31:0] inst);
        dec_t d;
        logic [6:0] opc = inst[6:0];
        logic [2:0] f3 = inst[14:12];
        logic [6:0] f7 = inst[31:25];
        int uop = 15;
        bit r1 = 0, r2 = 0, wr = 0, mul = 0;
        logic [31:0] imm = 0;
        if (opc == 7'h13) begin
            r1 = 1; wr = 1; imm = {{20{inst[31]}}, inst[31:20]};
            if (f3 == 0) uop = 0;
            else if (f3 == 2) uop = 5;
            else if (f3 == 3) uop = 6;
            else if (f3 == 4) uop = 4;
            else if (f3 == 6) uop = 3;
            else if (f3 == 7) uop = 2;
            else begin
                imm = inst[24:20];
                if (f3 == 1 && f7 == 0) uop = 7;
                if (f3 == 5 && f7 == 0) uop = 8;
                if (f3 == 5 && f7 == 7'h20) uop = 9;
            end
        end else if (opc == 7'h33) begin
            r1 = 1; r2 = 1; wr = 1;
            if (f7 == 0) begin
                if (f3 == 0) uop = 0;
                if (f3 == 1) uop = 7;
                if (f3 == 2) uop = 5;
                if (f3 == 3) uop = 6;
                if (f3 == 4) uop = 4;
                if (f3 == 5) uop = 8;
                if (f3 == 6) uop = 3;
                if (f3 == 7) uop = 2;
            end else if (f7 == 7'h20 && f3 == 0) uop = 1;
            else if (f7 == 7'h20 && f3 == 5) uop = 9;
            else if (f7 == 7'h01 && f3 == 0) begin uop = 12; mul = 1; end
        end else if (opc == 7'h37) begin
            uop = 0; wr = 1; imm = {inst[31:12], 12'd0};
        end else if (opc == 7'h17) begin
            uop = 10; wr = 1; imm = {inst[31:12], 12'd0};
        end
        d = '0;
        if (uop != 15) begin
            d.uop  = 4'(uop);
            d.pipe = mul;
            d.rs1  = r1 ? inst[19:15] : 5'd0;
            d.rs2  = r2 ? inst[24:20] : 5'd0;
            d.rd   = wr ? inst[11:7] : 5'd0;
            d.imm  = imm;
            d.wen  = wr && inst[11:7] != 0;
        end else begin
            d.uop = 4'd15;
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 5));
        logic [4:0] rs1 = 5'($urandom_range(0, 5));
        logic [4:0] rs2 = 5'($urandom_range(0, 5));
        int k = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        if (k <= 2) opc = 7'h13;
        else if (k <= 5) opc = 7'h33;
        else if (k == 6) opc = 7'h37;
        else if (k == 7) opc = 7'h17;
        else if (k == 8) return $urandom;
        else begin opc = 7'h33; f7 = 7'h01; f3 = 3'd0; end
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int imm);
        return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_val = 0; bus.f_inst = 0; bus.f_pc = 0; bus.f_seq_num = 0;
        bus.x_rdy = 2'b11; bus.cmpl_val = 0; bus.cmpl_rd = 0; bus.cmpl_wen = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0;
        #2;
        n_checks++;
        if ({bus.x_val, bus.f_rdy} !== 3'b001) begin
            n_errors++; $display("FAIL reset_outputs: got x_val=%b f_rdy=%b want 00/1", bus.x_val, bus.f_rdy);
        end
        n_checks++;
        if (dut.pending_q !== 32'd0) begin
            n_errors++; $display("FAIL reset_pending: got %h want 0", dut.pending_q);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            n_checks++;
            if (bus.x_val !== 2'b00) begin
                n_errors++; $display("FAIL reset_idle: got x_val=%b want 00", bus.x_val);
            end
        end
        tick();
    endtask

    task automatic test_addi();
        bus.f_val = 1; bus.f_inst = 32'h00500093; bus.f_pc = 32'h200; bus.f_seq_num = 0;
        #2;
        n_checks++;
        if (bus.f_rdy !== 1'b1) begin
            n_errors++; $display("FAIL addi_accept: got f_rdy=%b want 1", bus.f_rdy);
        end
        tick(); bus.f_val = 0; #2;
        n_checks++;
        if (bus.x_val !== 2'b01) begin
            n_errors++; $display("FAIL addi_xval: got %b want 01", bus.x_val);
        end
        n_checks++;
        if ({bus.x_uop, bus.x_rs1, bus.x_rd, bus.x_imm, bus.x_wen, bus.x_pc, bus.x_seq_num}
            !== {4'd0, 5'd0, 5'd1, 32'd5, 1'b1, 32'h200, 5'd0}) begin
            n_errors++;
            $display("FAIL addi_fields: got uop=%0d rs1=%0d rd=%0d imm=%h wen=%b pc=%h seq=%0d want 0/0/1/5/1/200/0",
                     bus.x_uop, bus.x_rs1, bus.x_rd, bus.x_imm, bus.x_wen, bus.x_pc, bus.x_seq_num);
        end
        tick(); #2;
        n_checks++;
        if (dut.pending_q !== 32'h2) begin
            n_errors++; $display("FAIL addi_pending: got %h want 00000002", dut.pending_q);
        end
        tick();
    endtask

    task automatic test_raw();
        logic [1:0] exp_cmpl_cycle;
        bus.f_val = 1; bus.f_inst = 32'h00108133; bus.f_pc = 32'h204; bus.f_seq_num = 1;
        tick(); bus.f_val = 0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_checks++;
            if ({bus.x_val, bus.f_rdy} !== 3'b000) begin
                n_errors++; $display("FAIL raw_stall: got x_val=%b f_rdy=%b want 00/0", bus.x_val, bus.f_rdy);
            end
            tick();
        end
        bus.cmpl_val = 1; bus.cmpl_wen = 1; bus.cmpl_rd = 1;
`ifdef DECODE_ISSUE_CMPL_BYPASS_EN
        exp_cmpl_cycle = 2'b01;
`else
        exp_cmpl_cycle = 2'b00;
`endif
        #2;
        n_checks++;
        if (bus.x_val !== exp_cmpl_cycle) begin
            n_errors++; $display("FAIL raw_cmpl_cycle: got x_val=%b want %b", bus.x_val, exp_cmpl_cycle);
        end
        tick(); bus.cmpl_val = 0;
`ifndef DECODE_ISSUE_CMPL_BYPASS_EN
        #2;
        n_checks++;
        if ({bus.x_val, bus.x_rs1, bus.x_rs2, bus.x_rd} !== {2'b01, 5'd1, 5'd1, 5'd2}) begin
            n_errors++; $display("FAIL raw_issue: got x_val=%b rs1=%0d rs2=%0d rd=%0d want 01/1/1/2",
                                 bus.x_val, bus.x_rs1, bus.x_rs2, bus.x_rd);
        end
        tick();
`endif
        #2;
        n_checks++;
        if (dut.pending_q !== 32'h4) begin
            n_errors++; $display("FAIL raw_pending: got %h want 00000004", dut.pending_q);
        end
        tick();
        bus.cmpl_val = 1; bus.cmpl_rd = 2; tick(); bus.cmpl_val = 0;
    endtask

    task automatic test_mul_stall();
        bus.f_val = 1; bus.f_inst = 32'h025201b3; bus.f_pc = 32'h300; bus.f_seq_num = 2;
        tick(); bus.f_val = 0; bus.x_rdy = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if ({bus.x_val, bus.f_rdy, bus.x_uop, bus.x_rs1, bus.x_rs2, bus.x_rd, bus.x_wen, bus.x_pc}
                !== {2'b10, 1'b0, 4'd12, 5'd4, 5'd5, 5'd3, 1'b1, 32'h300}) begin
                n_errors++;
                $display("FAIL mul_hold: got x_val=%b f_rdy=%b uop=%0d rs1=%0d rs2=%0d rd=%0d wen=%b pc=%h want 10/0/12/4/5/3/1/300",
                         bus.x_val, bus.f_rdy, bus.x_uop, bus.x_rs1, bus.x_rs2, bus.x_rd, bus.x_wen, bus.x_pc);
            end
            tick();
        end
        bus.x_rdy = 2'b10; #2;
        n_checks++;
        if ({bus.x_val, bus.f_rdy} !== 3'b101) begin
            n_errors++; $display("FAIL mul_issue: got x_val=%b f_rdy=%b want 10/1", bus.x_val, bus.f_rdy);
        end
        tick(); bus.x_rdy = 2'b11; #2;
        n_checks++;
        if ({bus.x_val, dut.pending_q} !== {2'b00, 32'h8}) begin
            n_errors++; $display("FAIL mul_after: got x_val=%b pending=%h want 00/00000008", bus.x_val, dut.pending_q);
        end
        tick();
        bus.cmpl_val = 1; bus.cmpl_wen = 1; bus.cmpl_rd = 3; tick(); bus.cmpl_val = 0;
    endtask

    task automatic test_back_to_back();
        bus.x_rdy = 2'b11;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bus.f_val = 1; bus.f_inst = addi(6 + i, i + 1);
                bus.f_pc = 32'h400 + 32'(4 * i); bus.f_seq_num = 5'(i);
            end else begin
                bus.f_val = 0;
            end
            #2;
            if (i > 0) begin
                n_checks++;
                if ({bus.x_val, bus.f_rdy, bus.x_seq_num, bus.x_rd, bus.x_imm}
                    !== {2'b01, 1'b1, 5'(i - 1), 5'(5 + i), 32'(i)}) begin
                    n_errors++;
                    $display("FAIL b2b_issue%0d: got x_val=%b f_rdy=%b seq=%0d rd=%0d imm=%h want 01/1/%0d/%0d/%0d",
                             i, bus.x_val, bus.f_rdy, bus.x_seq_num, bus.x_rd, bus.x_imm, i - 1, 5 + i, i);
                end
            end
            tick();
        end
        for (int r = 6; r < 10; r++) begin
            bus.cmpl_val = 1; bus.cmpl_wen = 1; bus.cmpl_rd = 5'(r); tick();
        end
        bus.cmpl_val = 0; #2;
        n_checks++;
        if (dut.pending_q !== 32'd0) begin
            n_errors++; $display("FAIL b2b_drain: got pending=%h want 0", dut.pending_q);
        end
        tick();
    endtask

    task automatic test_illegal_reset();
        bus.f_val = 1; bus.f_inst = 32'hFFFFFFFF; bus.f_pc = 32'h500; bus.f_seq_num = 7;
        tick(); bus.f_val = 0; #2;
        n_checks++;
        if ({bus.x_val, bus.x_uop, bus.x_wen, bus.x_rs1, bus.x_rs2, bus.x_rd}
            !== {2'b01, 4'd15, 1'b0, 15'd0}) begin
            n_errors++; $display("FAIL illegal_fields: got x_val=%b uop=%0d wen=%b rs1=%0d rs2=%0d rd=%0d want 01/15/0/0/0/0",
                                 bus.x_val, bus.x_uop, bus.x_wen, bus.x_rs1, bus.x_rs2, bus.x_rd);
        end
        tick(); #2;
        n_checks++;
        if (dut.pending_q !== 32'd0) begin
            n_errors++; $display("FAIL illegal_pending: got %h want 0", dut.pending_q);
        end
        tick();
        bus.f_val = 1; bus.f_inst = 32'h00500093; bus.f_seq_num = 8; tick();
        bus.f_inst = 32'h00108133; bus.f_seq_num = 9; tick();
        bus.f_val = 0; #2;
        n_checks++;
        if ({bus.x_val, dut.pending_q} !== {2'b00, 32'h2}) begin
            n_errors++; $display("FAIL rst_setup: got x_val=%b pending=%h want 00/00000002", bus.x_val, dut.pending_q);
        end
        rst = 1; tick(); rst = 0; #2;
        n_checks++;
        if ({bus.x_val, bus.f_rdy, dut.pending_q} !== {2'b00, 1'b1, 32'd0}) begin
            n_errors++; $display("FAIL rst_midop: got x_val=%b f_rdy=%b pending=%h want 00/1/0",
                                 bus.x_val, bus.f_rdy, dut.pending_q);
        end
        tick();
    endtask

    task automatic test_random();
        dec_t        mh = '0;
        bit          mfull = 0;
        logic [31:0] mpc = 0, mpend = 0, cur_inst = 0, cur_pc = 0, clr, eff;
        logic [4:0]  mseq = 0, cur_seq = 0;
        int          cq[$];
        bit          have = 0, cpop, haz, issue, exp_frdy;
        logic [1:0]  exp_xval;
        idle_inputs();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!have) begin
                cur_inst = rand_inst(); cur_pc = $urandom & ~32'h3; cur_seq++; have = 1;
            end
            bus.f_val = ($urandom_range(0, 3) != 0);
            bus.f_inst = cur_inst; bus.f_pc = cur_pc; bus.f_seq_num = cur_seq;
            bus.x_rdy = 2'($urandom_range(0, 3));
            cpop = 0;
            if (cq.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.cmpl_val = 1; bus.cmpl_wen = 1; bus.cmpl_rd = 5'(cq[0]); cpop = 1;
            end else if ($urandom_range(0, 5) == 0) begin
                bus.cmpl_val = 1; bus.cmpl_wen = 0; bus.cmpl_rd = 5'($urandom_range(1, 5));
            end else begin
                bus.cmpl_val = 0; bus.cmpl_wen = 1'($urandom); bus.cmpl_rd = 5'($urandom_range(1, 5));
            end
            #2;
            clr = (bus.cmpl_val && bus.cmpl_wen && bus.cmpl_rd != 0) ? (32'd1 << bus.cmpl_rd) : 32'd0;
            eff = mpend;
`ifdef DECODE_ISSUE_CMPL_BYPASS_EN
            eff = eff & ~clr;
`endif
            haz = (mh.rs1 != 0 && eff[mh.rs1]) || (mh.rs2 != 0 && eff[mh.rs2]) || (mh.wen && eff[mh.rd]);
            exp_xval = (mfull && !haz) ? (mh.pipe ? 2'b10 : 2'b01) : 2'b00;
            issue = (exp_xval != 0) && bus.x_rdy[mh.pipe];
            exp_frdy = !mfull || issue;
            n_checks++;
            if ({bus.x_val, bus.f_rdy} !== {exp_xval, exp_frdy}) begin
                n_errors++; $display("FAIL rand_hs cyc%0d: got x_val=%b f_rdy=%b want %b/%b",
                                     cyc, bus.x_val, bus.f_rdy, exp_xval, exp_frdy);
            end
            n_checks++;
            if (dut.pending_q !== mpend) begin
                n_errors++; $display("FAIL rand_pending cyc%0d: got %h want %h", cyc, dut.pending_q, mpend);
            end
            if (exp_xval != 0) begin
                n_checks++;
                if ({bus.x_pc, bus.x_seq_num, bus.x_uop, bus.x_rs1, bus.x_rs2, bus.x_rd, bus.x_imm, bus.x_wen}
                    !== {mpc, mseq, mh.uop, mh.rs1, mh.rs2, mh.rd, mh.imm, mh.wen}) begin
                    n_errors++;
                    $display("FAIL rand_fields cyc%0d: got pc=%h seq=%0d uop=%0d rs1=%0d rs2=%0d rd=%0d imm=%h wen=%b want %h/%0d/%0d/%0d/%0d/%0d/%h/%b",
                             cyc, bus.x_pc, bus.x_seq_num, bus.x_uop, bus.x_rs1, bus.x_rs2, bus.x_rd,
                             bus.x_imm, bus.x_wen, mpc, mseq, mh.uop, mh.rs1, mh.rs2, mh.rd, mh.imm, mh.wen);
                end
            end
            if (cpop) void'(cq.pop_front());
            if (issue && mh.wen) cq.push_back(int'(mh.rd));
            mpend = (mpend & ~clr) | ((issue && mh.wen) ? (32'd1 << mh.rd) : 32'd0);
            if (bus.f_val && exp_frdy) begin
                mfull = 1; mh = ref_decode(cur_inst); mpc = cur_pc; mseq = cur_seq; have = 0;
            end else if (issue) begin
                mfull = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_addi();
        test_raw();
        test_mul_stall();
        test_back_to_back();
        test_illegal_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/decode_issue_unit.md
Name: decode_issue_unit

Overview:
In-order decode/issue stage directly downstream of the fetch unit; consumes the F->D stream (inst, pc, seq_num; val/rdy).
- Decodes an RV32I integer subset plus MUL into a micro-op.
- Holds one decoded instruction in a pipeline register.
- Stalls on RAW/WAW hazards tracked by a 32-entry pending-write scoreboard.
- Issues to pipe 0 (ALU) or pipe 1 (MUL); completion notifications clear scoreboard bits.

Parameters:
p_seq_num_bits, 5, width of sequence number carried from fetch to issue

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
f_val  input  1  fetch instruction valid
f_rdy  output  1  decode can accept
f_inst  input  32  instruction word
f_pc  input  32  instruction address
f_seq_num  input  p_seq_num_bits  sequence number
x_val  output  2  per-pipe issue valid; bit 0 ALU, bit 1 MUL; at most one set
x_rdy  input  2  per-pipe ready
x_pc  output  32  pc of issuing instruction
x_seq_num  output  p_seq_num_bits  seq num of issuing instruction
x_uop  output  4  micro-op
x_rs1  output  5  source reg 1
x_rs2  output  5  source reg 2
x_rd  output  5  destination reg
x_imm  output  32  sign-extended immediate
x_wen  output  1  writes rd
cmpl_val  input  1  writeback completion valid
cmpl_rd  input  5  completed destination
cmpl_wen  input  1  completion wrote a register

Behaviour:
- State: EMPTY / FULL, one-entry holding register of decoded fields.
- Reset: state EMPTY, pending = 0, all held fields 0. Outputs: x_val = 0, f_rdy = 1.
- Accept: f_xfer = f_val & f_rdy. f_rdy = EMPTY | issue_xfer (combinational through x_rdy).
- Issue: issue_xfer = FULL & !hazard & x_rdy[pipe]. x_val[pipe] = FULL & !hazard.
- Transitions:
  - EMPTY -> FULL on f_xfer.
  - FULL -> EMPTY on issue_xfer & !f_xfer.
  - FULL -> FULL on issue_xfer & f_xfer: new instruction loaded.
- Latency: accepted cycle N, earliest issue N+1. Throughput 1/cycle when hazard-free.
- Stall: while FULL and not issuing, all x_* fields hold stable.
- Decode uops:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, AUIPC 10, MUL 12, ILLEGAL 15.
  - OP-IMM/OP -> pipe 0. LUI -> ADD, rs1=0, U-imm. AUIPC -> uop 10, U-imm.
  - OP with funct7=0000001, funct3=000 -> MUL, pipe 1.
  - Every other encoding, including other M-extension funct3 values -> ILLEGAL, pipe 0, wen=0, rs1=rs2=rd=0.
- Immediates: I-type sign-extended; shift-imm uses inst[24:20] zero-extended; U-type is inst[31:12] followed by 12 zero bits.
- Register use:
  - rs1 used by OP, OP-IMM, MUL; rs2 used by OP, MUL; unused fields output 0.
  - x_wen = 1 only when rd != 0 and not ILLEGAL.
- Hazard: asserted when any used source, or rd when wen, has its pending bit set. x0 never hazards.
- Scoreboard update, each cycle:
  - Bit rd set on issue_xfer & x_wen.
  - Bit cleared on cmpl_val & cmpl_wen & cmpl_rd != 0.
  - Same-register set and clear in one cycle: set wins.
- Hazard is evaluated against the registered pending vector only; no same-cycle completion bypass unless the optional feature is enabled.
- Reset mid-operation: held instruction dropped, pending cleared, x_val = 0 the next cycle.

Optional Feature:
DECODE_ISSUE_CMPL_BYPASS_EN
- Defined: hazard check uses pending & ~clear_mask of the current cycle, so an instruction waiting on rd issues in the same cycle as its completion.
- Undefined: it issues one cycle after the completion.

Test Plan:
- Reset -> x_val=00, f_rdy=1, scoreboard all zero; no issue for 3 idle cycles.
- addi x1,x0,5 (0x00500093), pc 0x200, seq 0 -> next cycle x_val=01, uop 0, rs1=0, rd=1, imm=5, wen=1; after xfer pending[1]=1.
- Then add x2,x1,x1 (0x00108133) -> x_val=00, f_rdy=0 until cmpl_val rd=1. Issues the cycle after the completion (same cycle with macro); then pending[2]=1, pending[1]=0.
- mul x3,x4,x5 (0x025201b3) with x_rdy=01 for 3 cycles -> x_val=10, fields held stable, f_rdy=0; issues when x_rdy[1]=1, uop 12.
- Four independent addis at seq 0..3, f_val held high, x_rdy=11 -> issue on 4 consecutive cycles in seq order.
- 0xFFFFFFFF -> x_val=01, uop 15, wen=0, no scoreboard change. Assert rst while FULL with a hazard -> x_val=00 and pending=0 the next cycle.
